// File: rtl/serial_shares_loader_ctrl_pkg.sv
// Shared constants and state encoding for the serial shares loader and its share register bank.
package serial_shares_loader_ctrl_pkg;

    localparam int LDR_NBITS     = 4;
    localparam int LDR_MAX_WORDS = 8;
    localparam int LDR_D         = 2;
    localparam int LDR_W         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Index width needed to address n entries (at least one bit).
    function automatic int unsigned index_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_shares_loader_ctrl_index_counter.sv
// Share/word index counters for the serial loader; word wraps at the bound and carries into share.
module loader_index_counter
    import serial_shares_loader_ctrl_pkg::*;
#(
    parameter int NBITS = LDR_NBITS,
    parameter int d     = LDR_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [NBITS-1:0] bound,
    output logic [NBITS-1:0] share,
    output logic [NBITS-1:0] word,
    output logic             last
);

    localparam logic [NBITS-1:0] LAST_SHARE = NBITS'(d - 1);
    localparam logic [NBITS-1:0] ONE        = NBITS'(1);

    logic [NBITS-1:0] share_reg;
    logic [NBITS-1:0] word_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            share_reg <= '0;
            word_reg  <= '0;
        end else if (inc) begin
            if (word_reg == bound) begin
                word_reg  <= '0;
                share_reg <= share_reg + ONE;
            end else begin
                word_reg <= word_reg + ONE;
            end
        end
    end

    assign share = share_reg;
    assign word  = word_reg;
    assign last  = (share_reg == LAST_SHARE) && (word_reg == bound);

endmodule

// File: rtl/serial_shares_loader_ctrl.sv
// Sequences loading of d masked shares from a valid/ready word stream into the share register bank.
// Optional abort input enabled by defining SERIAL_LOADER_ABORT_EN.
module serial_shares_loader_ctrl
    import serial_shares_loader_ctrl_pkg::*;
#(
    parameter int NBITS               = LDR_NBITS,
    parameter int MAX_WORDS_PER_SHARE = LDR_MAX_WORDS,
    parameter int d                   = LDR_D,
    parameter int W                   = LDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] cfg_last_word,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
`ifdef SERIAL_LOADER_ABORT_EN
    input  logic             abort,
`endif
    output logic             in_ready,
    output logic             wr_en,
    output logic [NBITS-1:0] wr_share_idx,
    output logic [NBITS-1:0] wr_word_idx,
    output logic [W-1:0]     wr_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [NBITS:0] MAX_BOUND = (NBITS + 1)'(MAX_WORDS_PER_SHARE - 1);

    loader_state_t    state_reg, state_next;
    logic [NBITS-1:0] bound_reg;
    logic             cfg_err_reg, cfg_err_next;
    logic             start_ok;
    logic             cnt_clr;
    logic             cnt_last;
    logic             abort_req;

`ifdef SERIAL_LOADER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bound_reg   <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= cfg_err_next;
            if (start_ok) begin
                bound_reg <= cfg_last_word;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        in_ready     = 1'b0;
        done         = 1'b0;
        cnt_clr      = 1'b0;
        start_ok     = 1'b0;
        cfg_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if ({1'b0, cfg_last_word} <= MAX_BOUND) begin
                        start_ok   = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = LOAD;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Abort wins over a same-cycle transfer so no word is written after it.
                in_ready = !abort_req;
                if (abort_req) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (in_valid && cnt_last) begin
                    cnt_clr    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = !abort_req;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_en   = in_ready && in_valid;
    assign wr_data = in_data;
    assign busy    = (state_reg != IDLE);
    assign cfg_err = cfg_err_reg;

    loader_index_counter #(
        .NBITS (NBITS),
        .d     (d)
    ) u_index_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (wr_en),
        .bound (bound_reg),
        .share (wr_share_idx),
        .word  (wr_word_idx),
        .last  (cnt_last)
    );

endmodule

// File: tb/tb_serial_shares_loader_ctrl.sv
// Directed self-checking bench for serial_shares_loader_ctrl (d=2, MAX_WORDS_PER_SHARE=8).
module tb_serial_shares_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_last_word;
    logic [31:0] in_data;
    logic        in_valid;
`ifdef SERIAL_LOADER_ABORT_EN
    logic        abort;
`endif
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_share_idx;
    logic [3:0]  wr_word_idx;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_shares_loader_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_last_word (cfg_last_word),
        .in_data       (in_data),
        .in_valid      (in_valid),
`ifdef SERIAL_LOADER_ABORT_EN
        .abort         (abort),
`endif
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_share_idx  (wr_share_idx),
        .wr_word_idx   (wr_word_idx),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst = 1'b1; start = 1'b0; cfg_last_word = 4'd0; in_data = '0; in_valid = 1'b0;
`ifdef SERIAL_LOADER_ABORT_EN
        abort = 1'b0;
`endif
        next_cycle();
        next_cycle();
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        obs = {in_ready, wr_en, busy, done, cfg_err, wr_share_idx};
        checks++;
        if (obs !== 9'b0 || wr_word_idx !== 4'd0) begin
            $display("FAIL reset_state: got flags/share=%b word=%0d, need all zero", obs, wr_word_idx);
        end else begin
            passed++;
        end
        $display("reset: in_ready=%0b busy=%0b done=%0b", in_ready, busy, done);
        in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [9:0] obs, exp;
        start = 1'b1; cfg_last_word = 4'd3;
        next_cycle();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            obs = {wr_en, wr_share_idx, wr_word_idx, done};
            exp = {1'b1, 4'(k / 4), 4'(k % 4), 1'b0};
            checks++;
            if (obs !== exp || wr_data !== in_data || busy !== 1'b1) begin
                $display("FAIL b2b_xfer%0d: got en/share/word/done=%b data=%h busy=%0b, need %b data=%h busy=1",
                         k, obs, wr_data, busy, exp, in_data);
            end else begin
                passed++;
            end
            $display("b2b xfer %0d: share=%0d word=%0d data=%h", k, wr_share_idx, wr_word_idx, wr_data);
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({done, busy, in_ready, wr_en} !== 4'b1100) begin
            $display("FAIL b2b_done: got done/busy/ready/en=%b, need 1100", {done, busy, in_ready, wr_en});
        end else begin
            passed++;
        end
        in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL b2b_idle: got done/busy=%b, need 00", {done, busy});
        end else begin
            passed++;
        end
        $display("b2b: load complete");
        next_cycle();
    endtask

    task automatic test_stall();
        logic [8:0] obs, exp;
        int n;
        start = 1'b1; cfg_last_word = 4'd3;
        next_cycle();
        start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 32'h5000_0000 + 32'(c);
            n = (c + 1) / 2;   // transfers completed before this cycle
            @(negedge clk);
            obs = {wr_en, wr_share_idx, wr_word_idx};
            exp = {in_valid, 4'(n / 4), 4'(n % 4)};
            checks++;
            if (obs !== exp || done !== 1'b0) begin
                $display("FAIL stall_cyc%0d: got en/share/word=%b done=%0b, need %b done=0", c, obs, done, exp);
            end else begin
                passed++;
            end
            $display("stall cyc %0d: valid=%0b en=%0b share=%0d word=%0d", c, in_valid, wr_en, wr_share_idx, wr_word_idx);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b11) begin
            $display("FAIL stall_done: got done/busy=%b, need 11", {done, busy});
        end else begin
            passed++;
        end
        next_cycle();
    endtask

    task automatic test_bound_zero();
        logic [9:0] obs, exp;
        start = 1'b1; cfg_last_word = 4'd0;
        next_cycle();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 32'hB0 + 32'(k);
            @(negedge clk);
            obs = {wr_en, wr_share_idx, wr_word_idx, done};
            exp = {1'b1, 4'(k), 4'd0, 1'b0};
            checks++;
            if (obs !== exp) begin
                $display("FAIL bound0_xfer%0d: got en/share/word/done=%b, need %b", k, obs, exp);
            end else begin
                passed++;
            end
            $display("bound0 xfer %0d: share=%0d word=%0d", k, wr_share_idx, wr_word_idx);
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({done, in_ready} !== 2'b10) begin
            $display("FAIL bound0_done: got done/ready=%b, need 10", {done, in_ready});
        end else begin
            passed++;
        end
        in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_cfg_err();
        logic [9:0] obs, exp;
        start = 1'b1; cfg_last_word = 4'd8; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg_err, in_ready, busy} !== 3'b000) begin
            $display("FAIL cfgerr_same_cycle: got err/ready/busy=%b, need 000", {cfg_err, in_ready, busy});
        end else begin
            passed++;
        end
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({cfg_err, in_ready, busy, wr_en} !== 4'b1000) begin
            $display("FAIL cfgerr_pulse: got err/ready/busy/en=%b, need 1000", {cfg_err, in_ready, busy, wr_en});
        end else begin
            passed++;
        end
        $display("cfg_err: cfg_err=%0b in_ready=%0b", cfg_err, in_ready);
        next_cycle();
        @(negedge clk);
        checks++;
        if ({cfg_err, busy} !== 2'b00) begin
            $display("FAIL cfgerr_clear: got err/busy=%b, need 00", {cfg_err, busy});
        end else begin
            passed++;
        end
        start = 1'b1; cfg_last_word = 4'd1;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hC0 + 32'(k);
            @(negedge clk);
            obs = {wr_en, wr_share_idx, wr_word_idx, done};
            exp = {1'b1, 4'(k / 2), 4'(k % 2), 1'b0};
            checks++;
            if (obs !== exp) begin
                $display("FAIL legal_after_err_xfer%0d: got en/share/word/done=%b, need %b", k, obs, exp);
            end else begin
                passed++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL legal_after_err_done: got done=%0b, need 1", done);
        end else begin
            passed++;
        end
        next_cycle();
    endtask

    task automatic test_rst_midload();
        logic [9:0] obs, exp;
        start = 1'b1; cfg_last_word = 4'd3;
        next_cycle();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        obs = {in_ready, wr_en, busy, done, wr_share_idx, wr_word_idx[1:0]};
        checks++;
        if (obs !== 10'b0 || wr_word_idx !== 4'd0) begin
            $display("FAIL rst_midload: got ready/en/busy/done/share/word=%b, need all zero", obs);
        end else begin
            passed++;
        end
        $display("rst mid-load: in_ready=%0b busy=%0b", in_ready, busy);
        in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL rst_no_done: got done/busy=%b, need 00", {done, busy});
        end else begin
            passed++;
        end
        start = 1'b1;
        next_cycle();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 32'hD0 + 32'(k);
            @(negedge clk);
            obs = {wr_en, wr_share_idx, wr_word_idx, done};
            exp = {1'b1, 4'(k / 4), 4'(k % 4), 1'b0};
            checks++;
            if (obs !== exp) begin
                $display("FAIL restart_xfer%0d: got en/share/word/done=%b, need %b", k, obs, exp);
            end else begin
                passed++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL restart_done: got done=%0b, need 1", done);
        end else begin
            passed++;
        end
        next_cycle();
    endtask

`ifdef SERIAL_LOADER_ABORT_EN
    task automatic test_abort();
        start = 1'b1; cfg_last_word = 4'd3;
        next_cycle();
        start = 1'b0; in_valid = 1'b1;
        next_cycle();
        next_cycle();
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_en, in_ready, wr_share_idx, wr_word_idx} !== {1'b0, 1'b0, 4'd0, 4'd2}) begin
            $display("FAIL abort_suppress: got en=%0b ready=%0b share=%0d word=%0d, need 0 0 0 2",
                     wr_en, in_ready, wr_share_idx, wr_word_idx);
        end else begin
            passed++;
        end
        next_cycle();
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, in_ready, wr_share_idx, wr_word_idx} !== 11'b0) begin
            $display("FAIL abort_idle: got busy=%0b done=%0b ready=%0b share=%0d word=%0d, need all zero",
                     busy, done, in_ready, wr_share_idx, wr_word_idx);
        end else begin
            passed++;
        end
        $display("abort: busy=%0b done=%0b", busy, done);
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_bound_zero();
        test_cfg_err();
        test_rst_midload();
`ifdef SERIAL_LOADER_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
